// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and width constants for the pipeline memory stage
package pipeline_pkg;

  localparam int XLEN                   = 32;
  localparam int REG_AW                 = 5;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter flagging when an access has waited too long
module mem_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // expired is seen in the LIMIT-th waiting cycle, so the request stays up exactly LIMIT cycles
  assign expired = (count_q == 8'(LIMIT - 1));

  // clear wins over enable; hold at the limit so the count never wraps
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage with req/ready data memory handshake; optional MEM_ALIGN_CHECK_EN
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   data_1_in,
  input  logic [XLEN-1:0]   data_2_in,
  input  logic [REG_AW-1:0] Rd_in,
  input  logic              MEM_wen_in,
  input  logic              WB_sel_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_wen,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              valid_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic [REG_AW-1:0] Rd_out,
  output logic              WB_sel_out,
  output logic              err_out
);

  state_t              state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                wen_q, wen_d;
  logic                sel_q, sel_d;
  logic                req_q, req_d;
  logic                valid_out_q, valid_out_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic [REG_AW-1:0]   rd_out_q, rd_out_d;
  logic                wb_sel_out_q, wb_sel_out_d;
  logic                err_q, err_d;

  logic memop;
  logic misaligned;
  logic accept;
  logic abort;
  logic cnt_clear;
  logic cnt_en;
  logic expired;

  assign memop = MEM_wen_in | WB_sel_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |data_1_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && valid_in && memop && !misaligned;
  assign abort     = (state_q == WAIT) && !dmem_ready && expired;
  // drops in the completion/abort cycle so upstream advances without a bubble
  assign stall_out = accept || ((state_q == WAIT) && !dmem_ready && !abort);

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // next-state, capture and result logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wen_d        = wen_q;
    sel_d        = sel_q;
    req_d        = req_q;
    valid_out_d  = 1'b0;
    err_d        = 1'b0;
    wb_data_d    = wb_data_q;
    rd_out_d     = rd_out_q;
    wb_sel_out_d = wb_sel_out_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!memop) begin
            valid_out_d  = 1'b1;
            wb_data_d    = data_1_in;
            rd_out_d     = Rd_in;
            wb_sel_out_d = WB_sel_in;
          end else if (misaligned) begin
            valid_out_d  = 1'b1;
            err_d        = 1'b1;
            wb_data_d    = data_1_in;
            rd_out_d     = '0;
            wb_sel_out_d = WB_sel_in & ~MEM_wen_in;
          end else begin
            // a store wins if both enables are set, so the access is never a read
            addr_d    = data_1_in;
            wdata_d   = data_2_in;
            rd_d      = Rd_in;
            wen_d     = MEM_wen_in;
            sel_d     = WB_sel_in & ~MEM_wen_in;
            req_d     = 1'b1;
            cnt_clear = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          req_d        = 1'b0;
          valid_out_d  = 1'b1;
          wb_data_d    = sel_q ? dmem_rdata : addr_q;
          rd_out_d     = rd_q;
          wb_sel_out_d = sel_q;
          state_d      = IDLE;
        end else if (expired) begin
          req_d        = 1'b0;
          valid_out_d  = 1'b1;
          err_d        = 1'b1;
          wb_data_d    = addr_q;
          rd_out_d     = '0;
          wb_sel_out_d = sel_q;
          state_d      = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // state and output registers; reset discards any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      sel_q        <= 1'b0;
      req_q        <= 1'b0;
      valid_out_q  <= 1'b0;
      wb_data_q    <= '0;
      rd_out_q     <= '0;
      wb_sel_out_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wen_q        <= wen_d;
      sel_q        <= sel_d;
      req_q        <= req_d;
      valid_out_q  <= valid_out_d;
      wb_data_q    <= wb_data_d;
      rd_out_q     <= rd_out_d;
      wb_sel_out_q <= wb_sel_out_d;
      err_q        <= err_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_wen    = wen_q;
  assign dmem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata  = wdata_q;
  assign valid_out   = valid_out_q;
  assign wb_data_out = wb_data_q;
  assign Rd_out      = rd_out_q;
  assign WB_sel_out  = wb_sel_out_q;
  assign err_out     = err_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs: ALU result/address, store data, destination register, memory write enable and write-back select. It drives the data memory through a req/ready handshake, stalls upstream while an access is outstanding, and presents registered results to the MEM/WB register. Non-memory instructions pass through with one cycle of latency.

## Interface
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before an access is aborted; legal range 2..255.
- clk  in  1  pipeline clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX/MEM slot holds a live instruction.
- data_1_in  in  32  ALU result; byte address for loads and stores.
- data_2_in  in  32  store data.
- Rd_in  in  5  destination register.
- MEM_wen_in  in  1  store.
- WB_sel_in  in  1  load; write-back takes memory data.
- stall_out  out  1  hold EX/MEM and earlier stages.
- dmem_req  out  1  memory request, registered.
- dmem_wen  out  1  request is a write.
- dmem_addr  out  32  word address, with bits [1:0] forced to 0.
- dmem_wdata  out  32  write data.
- dmem_ready  in  1  memory accepts or completes the request this cycle.
- dmem_rdata  in  32  read data; valid when dmem_ready is high.
- valid_out  out  1  result valid for MEM/WB, one-cycle pulse per instruction.
- wb_data_out  out  32  load data, or data_1_in for non-load instructions.
- Rd_out  out  5  destination register; forced to 0 on abort.
- WB_sel_out  out  1  registered WB_sel.
- err_out  out  1  one-cycle pulse on timeout or misalignment abort.

## Operation
- Memory op (memop) = MEM_wen_in | WB_sel_in. Asserting both MEM_wen_in and WB_sel_in is illegal; the write takes priority.
- FSM has two states, IDLE and WAIT.
- **IDLE, valid_in & !memop:**
  - Register valid_out=1, wb_data_out=data_1_in, Rd_out, WB_sel_out.
  - Stay in IDLE.
- **IDLE, valid_in & memop:**
  - Capture address, data, Rd, wen and sel.
  - Set dmem_req=1 and clear the timeout counter.
  - Go to WAIT.
  - valid_out=0 next cycle.
- **WAIT, dmem_ready=1:**
  - Clear dmem_req.
  - Register valid_out=1; wb_data_out = dmem_rdata for a load, or the captured address for a store.
  - Go to IDLE.
- **WAIT, dmem_ready=0:**
  - Counter increments.
  - At counter == TIMEOUT_CYCLES-1, abort: clear dmem_req, valid_out=1, Rd_out=0, err_out=1, go to IDLE.
- dmem_addr, dmem_wen and dmem_wdata are stable for the whole time dmem_req is high.
- **stall_out** (combinational) = (IDLE & valid_in & memop) | (WAIT & !dmem_ready & !abort). It falls in the completion cycle, so upstream advances in that same cycle.
- **Reset:** all outputs 0, FSM to IDLE, counter 0.
  - Reset mid-WAIT drops dmem_req immediately.
  - The in-flight instruction is lost; no valid_out is produced for it.

## Timing
- Non-memory op: accepted at cycle N, valid_out at N+1, no stall.
- Memory op accepted at N:
  - dmem_req is high from N+1.
  - If ready arrives at cycle N+k, valid_out is at N+k+1.
  - Minimum latency is 2 cycles, with stall_out high for cycles N..N+k-1.
- Timeout: dmem_req is high for TIMEOUT_CYCLES cycles, then err_out and valid_out pulse on the following cycle.
- Back-to-back: a new instruction is accepted in the first IDLE cycle after completion. There are no bubbles beyond the access latency.
- dmem_ready while in IDLE is ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A memop in IDLE with data_1_in[1:0] != 0 issues no request.
  - Next cycle: valid_out=1, Rd_out=0, err_out=1, no stall.
- MEM_ALIGN_CHECK_EN undefined: low address bits are silently dropped.

## Structure
- Shared package `pipeline_pkg` holds:
  - the state enum (IDLE, WAIT);
  - the width constants XLEN=32 and REG_AW=5;
  - the default TIMEOUT_CYCLES.
- One sub-module is natural: `mem_timeout_counter`, which takes clear/enable and outputs expired.

## Test plan
- ALU op: valid_in=1, data_1_in=0x0000_1234, Rd_in=5 -> next cycle valid_out=1, wb_data_out=0x1234, Rd_out=5, dmem_req never high.
- Load with ready on the first cycle: addr 0x100, dmem_rdata=0xDEADBEEF -> dmem_req high 1 cycle, stall_out high 1 cycle, valid_out at N+2, wb_data_out=0xDEADBEEF.
- Store with 3 wait cycles: addr 0x200, data 0xCAFE0001 -> dmem_wen=1 and dmem_wdata held stable for 4 cycles, stall_out high cycles N..N+3, valid_out at N+5.
- Timeout: load, dmem_ready tied 0, TIMEOUT_CYCLES=16 -> dmem_req high 16 cycles, then err_out=1, valid_out=1, Rd_out=0, FSM back in IDLE.
- Reset asserted mid-WAIT -> dmem_req, stall_out and valid_out go to 0 asynchronously; after release, an ALU op completes normally.
- With MEM_ALIGN_CHECK_EN defined: load at addr 0x102 -> no dmem_req, err_out=1 next cycle, Rd_out=0.
